// File: rtl/lift_call_scheduler.sv
// Hall-call latching and motor sequencing for a 3-floor lift: homes to floor 0, serves calls in
// collective order, dwells with the door open and traps to a sticky fault.
module lift_call_scheduler #(
  parameter int unsigned DWELL_CYCLES   = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic       call0,
  input  logic       call1,
  input  logic       call2,
  input  logic       bottom,
  input  logic       middle_plus,
  input  logic       middle_minus,
  input  logic       top,
  output logic       direction,
  output logic       enable,
  output logic       indicator0,
  output logic       indicator1,
  output logic       indicator2,
  output logic       door_open,
  output logic [1:0] floor,
  output logic       fault
);
  localparam int unsigned DwW = $clog2(DWELL_CYCLES + 1);
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DwW-1:0] DwellLast = DwW'(DWELL_CYCLES - 1);
  localparam logic [WdW-1:0] WdogLast  = WdW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StHome, StIdle, StUp, StDown, StDoor, StFault} state_e;

  state_e           r_state;
  logic [2:0]       r_pend;
  logic [1:0]       r_floor;
  logic             r_dir_up;
  logic [DwW-1:0]   r_dwell;
  logic [WdW-1:0]   r_wdog;
  logic             r_enable, r_direction, r_door, r_fault;

  state_e           w_state_pre, w_state_nxt;
  logic [1:0]       w_floor_nxt;
  logic [2:0]       w_calls, w_block, w_clear, w_pend_nxt;
  logic             w_here, w_above, w_below, w_call_here;
  logic             w_go_up, w_go_down;
  logic             w_motion, w_timeout, w_sensor_bad, w_arrive;
  logic [DwW-1:0]   w_dwell_nxt;
  logic [WdW-1:0]   w_wdog_nxt;

  assign w_calls = {call2, call1, call0};

  always_comb begin
    w_here      = 1'b0;
    w_above     = 1'b0;
    w_below     = 1'b0;
    w_call_here = 1'b0;
    case (r_floor)
      2'd0: begin
        w_here      = r_pend[0];
        w_above     = r_pend[1] | r_pend[2];
        w_call_here = call0;
      end
      2'd1: begin
        w_here      = r_pend[1];
        w_above     = r_pend[2];
        w_below     = r_pend[0];
        w_call_here = call1;
      end
      default: begin
        w_here      = r_pend[2];
        w_below     = r_pend[0] | r_pend[1];
        w_call_here = call2;
      end
    endcase
    // Prefer the last travel direction; otherwise take whichever side has work.
    w_go_up   = w_above & (r_dir_up | ~w_below);
    w_go_down = w_below & ~w_go_up;
  end

  always_comb begin
    w_state_pre = r_state;
    w_floor_nxt = r_floor;
    case (r_state)
      StHome: begin
        if (bottom) begin
          w_floor_nxt = 2'd0;
          w_state_pre = StIdle;
        end
      end
      StIdle: begin
        if (w_here)         w_state_pre = StDoor;
        else if (w_go_up)   w_state_pre = StUp;
        else if (w_go_down) w_state_pre = StDown;
      end
      StUp: begin
        if (top) begin
          w_floor_nxt = 2'd2;
          w_state_pre = StDoor;
        end else if (middle_plus && r_floor == 2'd0) begin
          w_floor_nxt = 2'd1;
          if (r_pend[1]) w_state_pre = StDoor;
        end
      end
      StDown: begin
        if (bottom) begin
          w_floor_nxt = 2'd0;
          w_state_pre = StDoor;
        end else if (middle_minus && r_floor == 2'd2) begin
          w_floor_nxt = 2'd1;
          if (r_pend[1]) w_state_pre = StDoor;
        end
      end
      StDoor: begin
        if (!w_call_here && r_dwell == DwellLast) begin
          if (w_go_up)        w_state_pre = StUp;
          else if (w_go_down) w_state_pre = StDown;
          else                w_state_pre = StIdle;
        end
      end
      default: ;
    endcase

    w_motion     = (r_state == StHome) || (r_state == StUp) || (r_state == StDown);
    w_timeout    = w_motion && (w_state_pre == r_state) && (r_wdog == WdogLast);
    w_sensor_bad = (bottom & top) | (middle_plus & middle_minus & (bottom | top));
    w_state_nxt  = (w_sensor_bad || w_timeout) ? StFault : w_state_pre;
    w_arrive     = (w_state_nxt == StDoor) && (r_state != StDoor);

    // A call at the open door's floor does not latch; it restarts the dwell instead.
    w_block    = (r_state == StDoor) ? 3'(3'b001 << r_floor) : 3'b000;
    w_clear    = w_arrive ? 3'(3'b001 << w_floor_nxt) : 3'b000;
    w_pend_nxt = (r_pend | (w_calls & ~w_block)) & ~w_clear;

    w_dwell_nxt = r_dwell;
    if (w_arrive || (r_state == StDoor && w_call_here)) begin
      w_dwell_nxt = '0;
    end else if (r_state == StDoor && r_dwell != DwellLast) begin
      w_dwell_nxt = r_dwell + DwW'(1);
    end

    w_wdog_nxt = r_wdog;
    if (w_state_nxt != r_state)  w_wdog_nxt = '0;
    else if (r_wdog != WdogLast) w_wdog_nxt = r_wdog + WdW'(1);
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state     <= StHome;
      r_pend      <= 3'b000;
      r_floor     <= 2'd0;
      r_dir_up    <= 1'b1;
      r_dwell     <= '0;
      r_wdog      <= '0;
      r_enable    <= 1'b0;
      r_direction <= 1'b0;
      r_door      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend      <= w_pend_nxt;
      r_floor     <= w_floor_nxt;
      r_dwell     <= w_dwell_nxt;
      r_wdog      <= w_wdog_nxt;
      if (w_state_nxt == StUp)        r_dir_up <= 1'b1;
      else if (w_state_nxt == StDown) r_dir_up <= 1'b0;
      r_enable    <= (w_state_nxt == StHome) || (w_state_nxt == StUp) ||
                     (w_state_nxt == StDown);
      r_direction <= (w_state_nxt == StUp);
      r_door      <= (w_state_nxt == StDoor);
      r_fault     <= (w_state_nxt == StFault);
    end
  end

  assign direction  = r_direction;
  assign enable     = r_enable;
  assign indicator0 = r_pend[0];
  assign indicator1 = r_pend[1];
  assign indicator2 = r_pend[2];
  assign door_open  = r_door;
  assign floor      = r_floor;
  assign fault      = r_fault;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Bench for lift_call_scheduler: directed vector table, hand-built corner sequences and a
// randomised run against a behavioural lift model driving a simple shaft plant.
module tb_lift_call_scheduler;
  localparam int unsigned Dwell   = 4;
  localparam int unsigned Timeout = 20;
  localparam logic [3:0] SB  = 4'b1000;
  localparam logic [3:0] SMP = 4'b0100;
  localparam logic [3:0] SMM = 4'b0010;
  localparam logic [3:0] ST  = 4'b0001;

  logic clock = 1'b0;
  logic n_reset = 1'b0;
  logic call0 = 1'b0, call1 = 1'b0, call2 = 1'b0;
  logic bottom = 1'b0, middle_plus = 1'b0, middle_minus = 1'b0, top = 1'b0;
  logic direction, enable, indicator0, indicator1, indicator2, door_open, fault;
  logic [1:0] floor;

  int n_tests = 0;
  int n_fail  = 0;

  lift_call_scheduler #(.DWELL_CYCLES(Dwell), .TIMEOUT_CYCLES(Timeout)) dut (
    .clock(clock), .n_reset(n_reset),
    .call0(call0), .call1(call1), .call2(call2),
    .bottom(bottom), .middle_plus(middle_plus), .middle_minus(middle_minus), .top(top),
    .direction(direction), .enable(enable),
    .indicator0(indicator0), .indicator1(indicator1), .indicator2(indicator2),
    .door_open(door_open), .floor(floor), .fault(fault)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  typedef struct packed {
    logic [2:0] c;
    logic [3:0] s;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[$];

  // {fault, floor, door_open, indicator2..0, enable, direction}
  function automatic logic [8:0] ev(input logic flt, input logic [1:0] fl, input logic dr,
                                    input logic [2:0] ind, input logic en, input logic di);
    return {flt, fl, dr, ind, en, di};
  endfunction

  function automatic logic [8:0] outv();
    return {fault, floor, door_open, indicator2, indicator1, indicator0, enable, direction};
  endfunction

  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic add(input logic [2:0] c, input logic [3:0] s, input logic [8:0] e);
    vec_t v;
    v.c = c; v.s = s; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [2:0] c, input logic [3:0] s);
    {call2, call1, call0} = c;
    {bottom, middle_plus, middle_minus, top} = s;
  endtask

  task automatic tick(input logic [2:0] c, input logic [3:0] s);
    drive(c, s);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string name);
    n_reset = 1'b0;
    drive(3'b000, 4'b0000);
    #7;
    chk({name, " reset"}, outv(), 9'b0);
    @(negedge clock);
    n_reset = 1'b1;
  endtask

  // Behavioural model: car mode as homing flag, travel sign and door countdown.
  bit         m_hom, m_fault;
  int         m_mot, m_door, m_floor, m_pref, m_age;
  logic [2:0] m_pend;
  logic       m_en, m_dir, m_dopen;

  task automatic m_reset();
    m_hom = 1; m_fault = 0; m_mot = 0; m_door = 0; m_floor = 0; m_pref = 1; m_age = 0;
    m_pend = 3'b000; m_en = 0; m_dir = 0; m_dopen = 0;
  endtask

  function automatic int choose(input logic [2:0] pend, input int fl, input int pref);
    bit up_w, dn_w;
    up_w = 0; dn_w = 0;
    for (int i = 0; i < 3; i++) begin
      if (pend[i] && i > fl) up_w = 1;
      if (pend[i] && i < fl) dn_w = 1;
    end
    if (up_w && dn_w) return pref;
    if (up_w) return 1;
    if (dn_w) return -1;
    return 0;
  endfunction

  task automatic m_step(input logic [2:0] c, input logic b, input logic mp, input logic mm,
                        input logic t);
    bit bad, arrive, to, nhom, moving;
    int nf, nmot, ndoor;
    logic [2:0] np;
    bad = (b && t) || (mp && mm && (b || t));
    nf = m_floor; nmot = m_mot; nhom = m_hom; ndoor = m_door; arrive = 0; to = 0;
    if (m_fault) begin
    end else if (m_hom) begin
      if (b) begin nhom = 0; nf = 0; end
    end else if (m_mot == 1) begin
      if (t) begin nf = 2; arrive = 1; end
      else if (mp && m_floor == 0) begin nf = 1; arrive = m_pend[1]; end
    end else if (m_mot == -1) begin
      if (b) begin nf = 0; arrive = 1; end
      else if (mm && m_floor == 2) begin nf = 1; arrive = m_pend[1]; end
    end else if (m_door > 0) begin
      if (c[m_floor]) ndoor = Dwell;
      else if (m_door == 1) begin ndoor = 0; nmot = choose(m_pend, m_floor, m_pref); end
      else ndoor = m_door - 1;
    end else begin
      if (m_pend[m_floor]) arrive = 1;
      else nmot = choose(m_pend, m_floor, m_pref);
    end
    if (arrive) begin nmot = 0; ndoor = Dwell; end
    moving = m_hom || (m_mot != 0);
    if (moving && nhom == m_hom && nmot == m_mot && !arrive) begin
      if (m_age + 1 >= Timeout) to = 1;
      else m_age++;
    end else m_age = 0;
    if (!m_fault && (bad || to)) begin
      m_fault = 1; nhom = 0; nmot = 0; ndoor = 0; arrive = 0;
    end
    for (int i = 0; i < 3; i++) np[i] = m_pend[i] | (c[i] && !(m_door > 0 && m_floor == i));
    if (arrive) np[nf] = 1'b0;
    if (nmot != 0) m_pref = nmot;
    m_hom = nhom; m_mot = nmot; m_door = ndoor; m_floor = nf; m_pend = np;
    m_en = !m_fault && (m_hom || m_mot != 0);
    m_dir = (m_mot == 1);
    m_dopen = (m_door > 0);
  endtask

  initial begin
    // Home, call to 2 passing middle, dwell, call to 0 with a stop at 1, reload, reverse.
    add(3'b000, 4'b0000, ev(0, 0, 0, 3'b000, 1, 0));
    add(3'b000, 4'b0000, ev(0, 0, 0, 3'b000, 1, 0));
    add(3'b000, 4'b0000, ev(0, 0, 0, 3'b000, 1, 0));
    add(3'b000, SB,      ev(0, 0, 0, 3'b000, 0, 0));
    add(3'b100, SB,      ev(0, 0, 0, 3'b100, 0, 0));
    add(3'b000, SB,      ev(0, 0, 0, 3'b100, 1, 1));
    add(3'b000, 4'b0000, ev(0, 0, 0, 3'b100, 1, 1));
    add(3'b000, SMP,     ev(0, 1, 0, 3'b100, 1, 1));
    add(3'b000, 4'b0000, ev(0, 1, 0, 3'b100, 1, 1));
    add(3'b000, ST,      ev(0, 2, 1, 3'b000, 0, 0));
    for (int i = 0; i < 3; i++) add(3'b000, ST, ev(0, 2, 1, 3'b000, 0, 0));
    add(3'b000, ST,      ev(0, 2, 0, 3'b000, 0, 0));
    add(3'b001, ST,      ev(0, 2, 0, 3'b001, 0, 0));
    add(3'b000, ST,      ev(0, 2, 0, 3'b001, 1, 0));
    add(3'b010, 4'b0000, ev(0, 2, 0, 3'b011, 1, 0));
    add(3'b000, SMM,     ev(0, 1, 1, 3'b001, 0, 0));
    add(3'b010, 4'b0000, ev(0, 1, 1, 3'b001, 0, 0));
    add(3'b010, 4'b0000, ev(0, 1, 1, 3'b001, 0, 0));
    add(3'b100, 4'b0000, ev(0, 1, 1, 3'b101, 0, 0));
    add(3'b000, 4'b0000, ev(0, 1, 1, 3'b101, 0, 0));
    add(3'b000, 4'b0000, ev(0, 1, 1, 3'b101, 0, 0));
    add(3'b000, 4'b0000, ev(0, 1, 0, 3'b101, 1, 0));
    add(3'b000, SB,      ev(0, 0, 1, 3'b100, 0, 0));
    for (int i = 0; i < 3; i++) add(3'b000, SB, ev(0, 0, 1, 3'b100, 0, 0));
    add(3'b000, SB,      ev(0, 0, 0, 3'b100, 1, 1));
    add(3'b000, SMP,     ev(0, 1, 0, 3'b100, 1, 1));
    add(3'b000, ST,      ev(0, 2, 1, 3'b000, 0, 0));

    do_reset("table");
    foreach (tbl[i]) begin
      tick(tbl[i].c, tbl[i].s);
      chk($sformatf("row %0d", i + 1), outv(), tbl[i].exp);
    end

    // Stop at 1 on the way up, then collective rule keeps going up past a pending call 0.
    do_reset("collective");
    tick(3'b000, SB);
    tick(3'b100, 4'b0000);
    tick(3'b000, 4'b0000);
    tick(3'b010, 4'b0000);
    tick(3'b001, 4'b0000);
    chk("latched while leaving", outv(), ev(0, 0, 0, 3'b111, 1, 1));
    tick(3'b000, SMP);
    chk("stop at 1", outv(), ev(0, 1, 1, 3'b101, 0, 0));
    for (int i = 0; i < 3; i++) tick(3'b000, 4'b0000);
    chk("dwell last cycle", outv(), ev(0, 1, 1, 3'b101, 0, 0));
    tick(3'b000, 4'b0000);
    chk("up first", outv(), ev(0, 1, 0, 3'b101, 1, 1));
    tick(3'b000, ST);
    chk("serve 2", outv(), ev(0, 2, 1, 3'b001, 0, 0));

    // Motion watchdog.
    do_reset("timeout");
    tick(3'b000, SB);
    tick(3'b100, 4'b0000);
    tick(3'b000, 4'b0000);
    for (int i = 0; i < Timeout - 1; i++) tick(3'b000, 4'b0000);
    chk("wdog edge-1", outv(), ev(0, 0, 0, 3'b100, 1, 1));
    tick(3'b000, 4'b0000);
    chk("wdog fault", 9'({fault, door_open, enable}), 9'b100);
    for (int i = 0; i < 3; i++) tick(3'b011, SB);
    chk("fault sticky", 9'({fault, door_open, enable}), 9'b100);

    // Sensor contradictions.
    do_reset("sensor_bt");
    tick(3'b000, SB);
    tick(3'b000, SB | ST);
    chk("bottom&top", 9'({fault, door_open, enable}), 9'b100);
    do_reset("sensor_mid");
    tick(3'b000, SB);
    tick(3'b000, SMP | SMM);
    chk("mid pair alone", 9'(fault), 9'b0);
    tick(3'b000, SMP | SMM | SB);
    chk("mid pair+bottom", 9'({fault, door_open, enable}), 9'b100);

    // Asynchronous reset while moving up, then re-home.
    do_reset("async");
    tick(3'b000, SB);
    tick(3'b100, 4'b0000);
    tick(3'b000, 4'b0000);
    chk("moving up", 9'({enable, direction}), 9'b11);
    #2;
    n_reset = 1'b0;
    #1;
    chk("async enable drop", 9'(enable), 9'b0);
    @(negedge clock);
    n_reset = 1'b1;
    tick(3'b000, 4'b0000);
    chk("rehome", outv(), ev(0, 0, 0, 3'b000, 1, 0));

    // Randomised calls against the model with a shaft plant: floors at 0, 6 and 12.
    begin
      int p;
      logic [2:0] cc;
      logic sb, smp, smm, st;
      m_reset();
      do_reset("random");
      p = $urandom_range(0, 12);
      for (int k = 0; k < 500; k++) begin
        sb  = (p == 0);
        st  = (p == 12);
        smp = (p == 6) && m_en && m_dir;
        smm = (p == 6) && m_en && !m_dir;
        cc  = {($urandom_range(0, 11) == 0), ($urandom_range(0, 11) == 0),
               ($urandom_range(0, 11) == 0)};
        drive(cc, {sb, smp, smm, st});
        @(posedge clock);
        m_step(cc, sb, smp, smm, st);
        #1;
        chk($sformatf("rand cyc %0d", k), outv(),
            {m_fault, 2'(m_floor), m_dopen, m_pend, m_en, m_dir});
        if (m_en) p = m_dir ? p + 1 : p - 1;
        if (p < 0) p = 0;
        if (p > 12) p = 12;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
